// File: rtl/instr_encoder_streamer_pkg.sv
// Shared encoding definitions: field widths, per-group opcode names and limits, request payload.
package instr_encoder_streamer_pkg;

  localparam int unsigned GROUP_W  = 4;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned IMM_W    = 32;
  localparam int unsigned WORD_W   = 32;

  // Instruction groups
  typedef enum logic [GROUP_W-1:0] {
    IOG_ALU_REG = 4'd0,
    IOG_ALU_IMM = 4'd1,
    IOG_BRANCH  = 4'd2,
    IOG_JUMP    = 4'd3,
    IOG_CALL    = 4'd4,
    IOG_LDST    = 4'd5,
    IOG_PORT    = 4'd6
  } iog_group_e;

  // Group 1 opcodes that the encoder treats specially
  typedef enum logic [OPCODE_W-1:0] {
    IOG1_ADDI  = 4'd0,
    IOG1_SLTSI = 4'd3,
    IOG1_SGTSI = 4'd5,
    IOG1_ADDSI = 4'd14,
    IOG1_CPYHI = 4'd15
  } iog1_oper_e;

  // Last legal opcode per group (groups 1 and 5 accept every opcode)
  localparam logic [OPCODE_W-1:0] G0_LAST_OP = 4'd13;
  localparam logic [OPCODE_W-1:0] G2_LAST_OP = 4'd9;
  localparam logic [OPCODE_W-1:0] G3_LAST_OP = 4'd9;
  localparam logic [OPCODE_W-1:0] G4_LAST_OP = 4'd9;
  localparam logic [OPCODE_W-1:0] G6_LAST_OP = 4'd6;

  // Decoded-form op descriptor
  typedef struct packed {
    logic [GROUP_W-1:0]  group;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    ra;
    logic [REG_W-1:0]    rb;
    logic [REG_W-1:0]    rc;
    logic [IMM_W-1:0]    imm;
    logic                wide;
  } enc_req_t;

  // True when v is representable as a 16-bit signed value
  function automatic logic fits_s16(input logic [IMM_W-1:0] v);
    return v[31:15] == {17{v[15]}};
  endfunction

  // True when v is representable as a 12-bit signed value
  function automatic logic fits_s12(input logic [IMM_W-1:0] v);
    return v[31:11] == {21{v[11]}};
  endfunction

endpackage

// File: rtl/instr_encoder_streamer_packer.sv
// Combinational descriptor-to-word packer with legality check.
module instr_word_packer
  import instr_encoder_streamer_pkg::*;
(
  input  enc_req_t          req,
  output logic [WORD_W-1:0] word,
  output logic              legal
);

  logic imm_signed_op;

  // Group 1 ops whose immediate is sign-extended by the decoder
  assign imm_signed_op = (req.opcode == IOG1_SLTSI) || (req.opcode == IOG1_SGTSI) ||
                         (req.opcode == IOG1_ADDSI);

  // Field packing and per-group legality; the wide pseudo-op overrides both
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (req.group)
      IOG_ALU_REG: begin
        word  = {req.group, req.ra, req.rb, req.rc, 12'h000, req.opcode};
        legal = (req.opcode <= G0_LAST_OP);
      end
      IOG_ALU_IMM: begin
        word  = {req.group, req.ra, req.rb, req.opcode, req.imm[15:0]};
        legal = imm_signed_op ? fits_s16(req.imm) : (req.imm[31:16] == 16'h0000);
      end
      IOG_BRANCH: begin
        word  = {req.group, req.ra, req.rb, req.opcode, req.imm[15:0]};
        legal = (req.opcode <= G2_LAST_OP) && fits_s16(req.imm);
      end
      IOG_JUMP: begin
        word  = {req.group, req.ra, req.rb, req.rc, 12'h000, req.opcode};
        legal = (req.opcode <= G3_LAST_OP);
      end
      IOG_CALL: begin
        word  = {req.group, req.ra, req.rb, req.rc, 12'h000, req.opcode};
        legal = (req.opcode <= G4_LAST_OP);
      end
      IOG_LDST: begin
        // Only the immediate-offset forms (opcode bit 3 set) carry an offset
        word  = {req.group, req.ra, req.rb, req.rc,
                 (req.opcode[3] ? req.imm[11:0] : 12'h000), req.opcode};
        legal = !req.opcode[3] || fits_s12(req.imm);
      end
      IOG_PORT: begin
        word  = {req.group, req.ra, req.rb, req.rc, 12'h000, req.opcode};
        legal = (req.opcode <= G6_LAST_OP);
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase

    if (req.wide) begin
      word  = {IOG_ALU_IMM, req.ra, 4'h0, IOG1_ADDI, req.imm[15:0]};
      legal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder_streamer.sv
// Streams packed instruction words with byte addresses; expands wide loads into Addi + Cpyhi.
module instr_encoder_streamer
  import instr_encoder_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_group,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [3:0]        in_rc,
  input  logic [31:0]       in_imm,
  input  logic              in_wide,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HI   = 1'b1
  } state_e;

  state_e            state_q;
  logic [15:0]       hi_imm_q;
  logic [REG_W-1:0]  hi_ra_q;
  logic [ADDR_W-1:0] addr_q;

  enc_req_t          req;
  logic [WORD_W-1:0] pack_word;
  logic              pack_legal;

  logic              slot_free;
  logic              out_hs;
  logic              accept;
  logic              bad_req;
  logic              emit_req;
  logic              emit_hi;
  logic              needs_hi;
  logic [ADDR_W-1:0] addr_next;

  // Handshake and control decode
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state_q == ST_IDLE) && slot_free;
  assign out_hs    = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign bad_req   = accept && !pack_legal;
  assign emit_req  = accept && pack_legal;
  assign emit_hi   = (state_q == ST_HI) && slot_free;
  assign needs_hi  = in_wide && (in_imm[31:16] != 16'h0000);
  // A word loaded in the same cycle as a handshake takes the following address
  assign addr_next = out_hs ? addr_q + ADDR_W'(4) : addr_q;

  // Descriptor payload
  assign req = '{group: in_group, opcode: in_opcode, ra: in_ra, rb: in_rb, rc: in_rc,
                 imm: in_imm, wide: in_wide};

  instr_word_packer u_packer (
    .req   (req),
    .word  (pack_word),
    .legal (pack_legal)
  );

  // FSM, output slot, address counter and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hi_imm_q  <= '0;
      hi_ra_q   <= '0;
      addr_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= bad_req;
      if (bad_req && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end

      addr_q <= addr_next;
      if (base_load && (state_q == ST_IDLE) && !out_valid && !accept) begin
        addr_q <= base_addr & ~ADDR_W'(3);
      end

      if (out_hs) begin
        out_valid <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (emit_req) begin
            out_valid <= 1'b1;
            out_data  <= pack_word;
            out_addr  <= addr_next;
            if (needs_hi) begin
              hi_imm_q <= in_imm[31:16];
              hi_ra_q  <= in_ra;
              state_q  <= ST_HI;
            end
          end
        end
        ST_HI: begin
          if (emit_hi) begin
            out_valid <= 1'b1;
            out_data  <= {IOG_ALU_IMM, hi_ra_q, 4'h0, IOG1_CPYHI, hi_imm_q};
            out_addr  <= addr_next;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_streamer.sv
// Scoreboard bench for instr_encoder_streamer with directed vectors.
module tb_instr_encoder_streamer;

  logic        clk;
  logic        rst_n;
  logic        base_load;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_group;
  logic [3:0]  in_opcode;
  logic [3:0]  in_ra;
  logic [3:0]  in_rb;
  logic [3:0]  in_rc;
  logic [31:0] in_imm;
  logic        in_wide;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        err_pulse;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  int   err_seen;
  int   words_seen;

  instr_encoder_streamer #(.ADDR_W(32), .ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_load (base_load),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_group  (in_group),
    .in_opcode (in_opcode),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_rc     (in_rc),
    .in_imm    (in_imm),
    .in_wide   (in_wide),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected words on every output handshake, checks stall stability
  logic        stall_q = 1'b0;
  logic [31:0] stall_data;
  logic [31:0] stall_addr;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_word", {out_data, out_addr}, {stall_data, stall_addr});
      end
      if (out_valid && out_ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got data %h addr %h with nothing expected", out_data, out_addr);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 64'(out_data), 64'(e.data));
          check("word_addr", 64'(out_addr), 64'(e.addr));
        end
      end
      if (err_pulse) err_seen++;
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_addr = out_addr;
    end
  end

  task automatic expect_word(input logic [31:0] d, input logic [31:0] a);
    exp_q.push_back('{data: d, addr: a});
  endtask

  // Present one descriptor and hold it until accepted (bounded)
  task automatic send(input logic [3:0] g, input logic [3:0] op, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [3:0] rc, input logic [31:0] imm,
                      input logic wide);
    int n;
    in_group  = g;
    in_opcode = op;
    in_ra     = ra;
    in_rb     = rb;
    in_rc     = rc;
    in_imm    = imm;
    in_wide   = wide;
    in_valid  = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready || n >= 50) break;
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_wide  = 1'b0;
  endtask

  // Wait for all expected words to leave the DUT (bounded)
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int words_before;
    vectors     = 0;
    miscompares = 0;
    err_seen    = 0;
    words_seen  = 0;
    rst_n     = 1'b0;
    base_load = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_group  = '0;
    in_opcode = '0;
    in_ra     = '0;
    in_rb     = '0;
    in_rc     = '0;
    in_imm    = '0;
    in_wide   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_err", {56'd0, err_pulse, err_count[6:0]}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Basic packing
    expect_word(32'h0123_0000, 32'd0);
    send(4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0);
    expect_word(32'h1450_1234, 32'd4);
    send(4'd1, 4'd0, 4'd4, 4'd5, 4'd0, 32'h0000_1234, 1'b0);
    check("legal_no_err", 64'(err_pulse), 64'd0);

    // Addi with out-of-range immediate
    send(4'd1, 4'd0, 4'd4, 4'd5, 4'd0, 32'h0001_0000, 1'b0);
    check("addi_err_pulse", 64'(err_pulse), 64'd1);
    check("addi_err_count", 64'(err_count), 64'd1);

    // Wide load needing two words; in_ready low while the high half is pending
    expect_word(32'h1700_BEEF, 32'd8);
    expect_word(32'h170F_DEAD, 32'd12);
    send(4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 32'hDEAD_BEEF, 1'b1);
    check("hi_in_ready", 64'(in_ready), 64'd0);
    expect_word(32'h1700_0042, 32'd16);
    send(4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 32'h0000_0042, 1'b1);

    // Load/store offsets
    expect_word(32'h5120_FFC8, 32'd20);
    send(4'd5, 4'd8, 4'd1, 4'd2, 4'd0, 32'hFFFF_FFFC, 1'b0);
    send(4'd5, 4'd8, 4'd1, 4'd2, 4'd0, 32'hFFFF_F000, 1'b0);
    check("ldri_err_count", 64'(err_count), 64'd2);
    send(4'd7, 4'd0, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0);
    check("g7_err_count", 64'(err_count), 64'd3);
    send(4'd0, 4'd14, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0);
    check("g0op14_err_count", 64'(err_count), 64'd4);
    expect_word(32'h1233_FFFF, 32'd24);
    send(4'd1, 4'd3, 4'd2, 4'd3, 4'd0, 32'hFFFF_FFFF, 1'b0);
    expect_word(32'h5678_0002, 32'd28);
    send(4'd5, 4'd2, 4'd6, 4'd7, 4'd8, 32'h0000_0123, 1'b0);
    send(4'd6, 4'd7, 4'd1, 4'd1, 4'd1, 32'd0, 1'b0);
    check("g6op7_err_count", 64'(err_count), 64'd5);
    expect_word(32'h3ABC_0009, 32'd32);
    send(4'd3, 4'd9, 4'hA, 4'hB, 4'hC, 32'd0, 1'b0);
    drain();
    check("err_pulses_seen", 64'(err_seen), 64'd5);

    // Backpressure in the middle of a wide pair
    out_ready = 1'b0;
    expect_word(32'h1300_0001, 32'd36);
    expect_word(32'h130F_CAFE, 32'd40);
    send(4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 32'hCAFE_0001, 1'b1);
    repeat (5) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Base reload with address wrap; a base_load while busy is ignored
    base_load = 1'b1;
    base_addr = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    base_load = 1'b0;
    expect_word(32'h0123_0000, 32'hFFFF_FFFC);
    send(4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0);
    base_load = 1'b1;
    base_addr = 32'h0000_0100;
    expect_word(32'h1450_1234, 32'h0000_0000);
    send(4'd1, 4'd0, 4'd4, 4'd5, 4'd0, 32'h0000_1234, 1'b0);
    base_load = 1'b0;
    drain();

    // Error counter saturation
    for (int i = 0; i < 252; i++) begin
      send(4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0);
    end
    check("err_sat", 64'(err_count), 64'd255);

    // Reset while the high half is pending
    out_ready = 1'b0;
    send(4'd0, 4'd0, 4'd9, 4'd0, 4'd0, 32'h0001_0002, 1'b1);
    rst_n = 1'b0;
    #2;
    check("rst_hi_out_valid", 64'(out_valid), 64'd0);
    check("rst_hi_out_addr", 64'(out_addr), 64'd0);
    check("rst_hi_err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    out_ready    = 1'b1;
    words_before = words_seen;
    repeat (10) @(posedge clk);
    #1;
    check("no_cpyhi_after_rst", 64'(words_seen), 64'(words_before));
    expect_word(32'h0123_0000, 32'd0);
    send(4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
